// File: rtl/psram_cmd_if.sv
// UART-byte and PSRAM access signals of the PSRAM command controller.
// master = controller side, slave = UART/PSRAM environment side.
interface psram_cmd_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic        tx_write;
  logic [7:0]  tx_data;
  logic        psram_stb;
  logic        psram_we;
  logic [23:0] psram_addr;
  logic [15:0] psram_din;
  logic        psram_busy;
  logic [15:0] psram_rdat;
  logic        cmd_err;

  modport master (
    input  rx_valid, rx_data, tx_busy, psram_busy, psram_rdat,
    output tx_write, tx_data, psram_stb, psram_we, psram_addr, psram_din, cmd_err
  );

  modport slave (
    output rx_valid, rx_data, tx_busy, psram_busy, psram_rdat,
    input  tx_write, tx_data, psram_stb, psram_we, psram_addr, psram_din, cmd_err
  );
endinterface

// File: rtl/psram_cmd_ctrl.sv
// UART-framed PSRAM read/write command controller; reads answer with two bytes, MSB first.
// Optional inter-byte timeout in COLLECT enabled by defining PSRAM_CMD_TIMEOUT_EN.
module psram_cmd_ctrl #(
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic        clk_out,
  input  logic        arst_n,
  input  logic        tick_1us,
  psram_cmd_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ISSUE, S_WAIT, S_TX_HI, S_TX_LO} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic        first_q, first_d;
  logic [15:0] rdat_q, rdat_d;
  logic        tx_write_q, tx_write_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] din_q, din_d;
  logic        err_q, err_d;
  logic [2:0]  need;

`ifdef PSRAM_CMD_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT_US);
  logic [15:0] timer_q, timer_d;
`else
  // No timer in this build; keep the timeout inputs referenced.
  logic [16:0] unused_timeout;
  assign unused_timeout = {tick_1us, 16'(TIMEOUT_US)};
`endif

  assign need = is_wr_q ? 3'd6 : 3'd4;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_wr_d    = is_wr_q;
    first_d    = first_q;
    rdat_d     = rdat_q;
    tx_write_d = 1'b0;
    tx_data_d  = tx_data_q;
    stb_d      = 1'b0;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    err_d      = 1'b0;
`ifdef PSRAM_CMD_TIMEOUT_EN
    timer_d    = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data[7:1] == 7'd0) begin
            state_d = S_COLLECT;
            cnt_d   = 3'd1;
            is_wr_d = bus.rx_data[0];
`ifdef PSRAM_CMD_TIMEOUT_EN
            timer_d = 16'd0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (cnt_q == need) begin
          // Frame complete: a byte arriving in this cycle is already too late.
          state_d = S_ISSUE;
          stb_d   = 1'b1;
          we_d    = is_wr_q;
          err_d   = bus.rx_valid;
        end else if (bus.rx_valid) begin
          case (cnt_q)
            3'd1:    addr_d[7:0]   = bus.rx_data;
            3'd2:    addr_d[15:8]  = bus.rx_data;
            3'd3:    addr_d[23:16] = bus.rx_data;
            3'd4:    din_d[7:0]    = bus.rx_data;
            default: din_d[15:8]   = bus.rx_data;
          endcase
          cnt_d = cnt_q + 3'd1;
`ifdef PSRAM_CMD_TIMEOUT_EN
          timer_d = 16'd0;
        end else if (tick_1us) begin
          if (timer_q + 16'd1 == TIMEOUT_CNT) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            timer_d = 16'd0;
            err_d   = 1'b1;
          end else begin
            timer_d = timer_q + 16'd1;
          end
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        first_d = 1'b1;
        cnt_d   = 3'd0;
        err_d   = bus.rx_valid;
      end
      S_WAIT: begin
        err_d = bus.rx_valid;
        // The PSRAM controller may not have raised busy yet in the first cycle.
        if (first_q) begin
          first_d = 1'b0;
        end else if (!bus.psram_busy) begin
          if (is_wr_q) begin
            state_d = S_IDLE;
          end else begin
            rdat_d  = bus.psram_rdat;
            state_d = S_TX_HI;
          end
        end
      end
      S_TX_HI: begin
        err_d = bus.rx_valid;
        if (!bus.tx_busy && !tx_write_q) begin
          tx_write_d = 1'b1;
          tx_data_d  = rdat_q[15:8];
          state_d    = S_TX_LO;
        end
      end
      S_TX_LO: begin
        err_d = bus.rx_valid;
        // The UART raises busy only after seeing our previous write.
        if (!bus.tx_busy && !tx_write_q) begin
          tx_write_d = 1'b1;
          tx_data_d  = rdat_q[7:0];
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_out or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      is_wr_q    <= 1'b0;
      first_q    <= 1'b0;
      rdat_q     <= 16'd0;
      tx_write_q <= 1'b0;
      tx_data_q  <= 8'd0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 24'd0;
      din_q      <= 16'd0;
      err_q      <= 1'b0;
`ifdef PSRAM_CMD_TIMEOUT_EN
      timer_q    <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_wr_q    <= is_wr_d;
      first_q    <= first_d;
      rdat_q     <= rdat_d;
      tx_write_q <= tx_write_d;
      tx_data_q  <= tx_data_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      err_q      <= err_d;
`ifdef PSRAM_CMD_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign bus.tx_write   = tx_write_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.psram_stb  = stb_q;
  assign bus.psram_we   = we_q;
  assign bus.psram_addr = addr_q;
  assign bus.psram_din  = din_q;
  assign bus.cmd_err    = err_q;

endmodule
